// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM port between two requesters.
// Sweeps the memory with INIT_VALUE after reset and on request, then serves traffic.
module dpram_port_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MEM_DEPTH  = 16,
  parameter int                    ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_din0,
  input  logic [DATA_WIDTH-1:0] i_din1,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_busy,
  output logic                  o_en_wr,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr_wr,
  output logic [DATA_WIDTH-1:0] o_din,
  output logic                  o_en_rd,
  output logic                  o_rd_n,
  output logic [ADDR_WIDTH-1:0] o_addr_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_dout
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam int PIPE_DEPTH = 1 + RD_LATENCY;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic                  prio1_q, prio1_d;
  logic [PIPE_DEPTH-1:0] pipe_vld_q, pipe_vld_d;
  logic [PIPE_DEPTH-1:0] pipe_id_q, pipe_id_d;
  logic                  en_wr_q, en_wr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_wr_q, addr_wr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  en_rd_q, en_rd_d;
  logic                  rd_n_q, rd_n_d;
  logic [ADDR_WIDTH-1:0] addr_rd_q, addr_rd_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  arb_ok;
  logic                  gnt0, gnt1, any_gnt, rd_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;
  logic                  ret_vld, ret_id;

  // prio1_q set means r0 was granted last, so r1 wins a tie
  always_comb begin
    arb_ok   = !rst && (state_q == ST_RUN) && !i_clear;
    gnt0     = arb_ok && i_req0 && (!i_req1 || !prio1_q);
    gnt1     = arb_ok && i_req1 && (!i_req0 || prio1_q);
    any_gnt  = gnt0 || gnt1;
    sel_we   = gnt1 ? i_we1   : i_we0;
    sel_addr = gnt1 ? i_addr1 : i_addr0;
    sel_din  = gnt1 ? i_din1  : i_din0;
    rd_gnt   = any_gnt && !sel_we;
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    prio1_d     = prio1_q;
    en_wr_d     = 1'b0;
    we_d        = 1'b0;
    en_rd_d     = 1'b0;
    rd_n_d      = 1'b1;
    addr_wr_d   = addr_wr_q;
    din_d       = din_q;
    addr_rd_d   = addr_rd_q;
    case (state_q)
      ST_INIT: begin
        en_wr_d   = 1'b1;
        we_d      = 1'b1;
        addr_wr_d = init_addr_q;
        din_d     = INIT_VALUE;
        if (init_addr_q == LAST_ADDR) begin
          init_addr_d = '0;
          state_d     = ST_RUN;
        end else begin
          init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (i_clear) begin
          state_d = ST_DRAIN;
        end else if (any_gnt) begin
          prio1_d = gnt0;
          if (sel_we) begin
            en_wr_d   = 1'b1;
            we_d      = 1'b1;
            addr_wr_d = sel_addr;
            din_d     = sel_din;
          end else begin
            en_rd_d   = 1'b1;
            rd_n_d    = 1'b0;
            addr_rd_d = sel_addr;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_vld_q == '0) begin
          state_d     = ST_INIT;
          init_addr_d = '0;
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_addr_d = '0;
      end
    endcase
  end

  // Tag pipeline lines up each read's requester id with its data from the RAM
  always_comb begin
    pipe_vld_d = {pipe_vld_q[PIPE_DEPTH-2:0], rd_gnt};
    pipe_id_d  = {pipe_id_q[PIPE_DEPTH-2:0], gnt1};
    ret_vld    = pipe_vld_q[PIPE_DEPTH-1];
    ret_id     = pipe_id_q[PIPE_DEPTH-1];
    rvalid0_d  = ret_vld && !ret_id;
    rvalid1_d  = ret_vld && ret_id;
    rdata0_d   = rvalid0_d ? i_mem_dout : rdata0_q;
    rdata1_d   = rvalid1_d ? i_mem_dout : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      prio1_q     <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_id_q   <= '0;
      en_wr_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_wr_q   <= '0;
      din_q       <= '0;
      en_rd_q     <= 1'b0;
      rd_n_q      <= 1'b1;
      addr_rd_q   <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      prio1_q     <= prio1_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_id_q   <= pipe_id_d;
      en_wr_q     <= en_wr_d;
      we_q        <= we_d;
      addr_wr_q   <= addr_wr_d;
      din_q       <= din_d;
      en_rd_q     <= en_rd_d;
      rd_n_q      <= rd_n_d;
      addr_rd_q   <= addr_rd_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign o_gnt0    = gnt0;
  assign o_gnt1    = gnt1;
  assign o_busy    = (state_q != ST_RUN);
  assign o_en_wr   = en_wr_q;
  assign o_we      = we_q;
  assign o_addr_wr = addr_wr_q;
  assign o_din     = din_q;
  assign o_en_rd   = en_rd_q;
  assign o_rd_n    = rd_n_q;
  assign o_addr_rd = addr_rd_q;
  assign o_rvalid0 = rvalid0_q;
  assign o_rvalid1 = rvalid1_q;
  assign o_rdata0  = rdata0_q;
  assign o_rdata1  = rdata1_q;

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one port of the dual-port RAM (single-clock use) between two requesters, r0 and r1, using round-robin arbitration.
- Drives the RAM's split write/read command pins and routes read data back to the requester that issued the read.
- After reset, and on demand, sweeps the whole memory with INIT_VALUE before it accepts traffic.
- Sits between client logic and one memory port; a second instance can own the other port.

Parameters:
- DATA_WIDTH, 8, data width of requesters and memory port.
- MEM_DEPTH, 16, number of memory locations.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width.
- RD_LATENCY, 1, cycles from a read command appearing on the memory pins to valid i_mem_dout (1 for the plain registered RAM).
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every location during INIT.

Ports:
- clk  in  1  single clock; the memory port clock is tied to it.
- rst  in  1  synchronous, active-high reset.
- i_clear  in  1  pulse that requests a full memory re-initialise.
- i_req0 / i_req1  in  1  request from r0 / r1; held until granted.
- i_we0 / i_we1  in  1  1 = write, 0 = read.
- i_addr0 / i_addr1  in  ADDR_WIDTH  request address.
- i_din0 / i_din1  in  DATA_WIDTH  write data.
- o_gnt0 / o_gnt1  out  1  request accepted this cycle (combinational).
- o_rvalid0 / o_rvalid1  out  1  one-cycle read-return strobe.
- o_rdata0 / o_rdata1  out  DATA_WIDTH  read-return data.
- o_busy  out  1  high whenever state != RUN.
- o_en_wr  out  1  memory write enable.
- o_we  out  1  memory write strobe.
- o_addr_wr  out  ADDR_WIDTH  memory write address.
- o_din  out  DATA_WIDTH  memory write data.
- o_en_rd  out  1  memory read enable.
- o_rd_n  out  1  memory read strobe, active-low (0 = read).
- o_addr_rd  out  ADDR_WIDTH  memory read address.
- i_mem_dout  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset values:
  - State INIT, init address 0, round-robin pointer "r0 first", return pipeline flushed.
  - o_en_wr=0, o_we=0, o_en_rd=0, o_rd_n=1.
  - All addresses, o_din, o_rdata0/1 = 0; o_rvalid0/1=0; o_busy=1.
  - o_gnt0/1 are 0 while rst is high.
- Memory command outputs are registered, with at most one command per cycle.
  - Write: o_en_wr=1, o_we=1, plus address and data.
  - Read: o_en_rd=1, o_rd_n=0, plus address.
  - Idle cycle: o_en_wr=0, o_we=0, o_en_rd=0, o_rd_n=1.
- FSM:
  - INIT:
    - Each cycle issues a write of INIT_VALUE to the init address, then increments it.
    - The write to MEM_DEPTH-1 is the last; next state is RUN.
    - INIT lasts exactly MEM_DEPTH cycles.
    - No grants; i_clear is ignored.
  - RUN:
    - Arbitration happens only in RUN.
    - If i_clear=1: no grant this cycle; next state DRAIN.
  - DRAIN:
    - No grants.
    - In-flight reads still return.
    - When the return pipeline is empty, next state INIT at address 0.
    - If the pipeline is already empty on entry, DRAIN lasts 1 cycle.
- Arbitration (RUN, i_clear=0):
  - Only one requester active: that requester is granted.
  - Both active: the one not granted most recently is granted.
  - The pointer updates only on a grant.
  - A granted request's command appears on the memory pins in the next cycle.
  - Consecutive granted commands execute in grant order, so a read granted after a write to the same address returns the new data.
- Read return:
  - A tag (valid, requester id) enters a (1+RD_LATENCY)-stage shift pipeline on each read grant.
  - On exit, o_rdataN is registered from i_mem_dout and o_rvalidN pulses for 1 cycle.
  - A read granted in cycle N returns in cycle N+2+RD_LATENCY (N+3 for default).
  - Back-to-back reads return back-to-back.
  - o_rdataN holds its last value when o_rvalidN=0.
  - Writes produce no return.
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid may appear after reset.
  - INIT restarts at address 0.

Test Plan:
- Reset release -> o_busy=1 for 16 cycles. Memory writes issue to addresses 0..15 with data 0x00. In cycle 17 o_busy=0 and an asserted i_req0 is granted.
- r0 writes 0xA5 to addr 3, then reads addr 3 -> o_rvalid0 pulses exactly 3 cycles after the read grant with o_rdata0=0xA5; o_rvalid1 stays 0.
- i_req0 and i_req1 both held high with reads to addr 1 and 2 (preloaded 0x11 and 0x22) -> grants alternate r0, r1, r0, r1. Returns alternate 0x11 and 0x22 on the matching port, one per cycle.
- r1 reads addr 5 (0x5C), then i_clear is pulsed the next cycle -> o_rvalid1 with 0x5C is still delivered. o_busy rises, DRAIN ends, INIT rewrites 0..15, and a later read of addr 5 returns 0x00.
- rst asserted one cycle after a read grant -> no o_rvalid in the following 5 cycles. Memory outputs take reset values and INIT restarts at address 0.
- RD_LATENCY=3 build, r0 read of addr 7 (0x7E) -> o_rvalid0 pulses 5 cycles after the grant with o_rdata0=0x7E.
